// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with RAW forwarding, load-use bubble insertion and
// ALU operand selection for the EX stage.
module id_ex_operand_stage #(
  parameter int DW  = 32,
  parameter int SCW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hold,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [4:0]    id_rs,
  input  logic [4:0]    id_rt,
  input  logic [4:0]    id_rd,
  input  logic          id_uses_rs,
  input  logic          id_uses_rt,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [4:0]    id_shamt,
  input  logic [4:0]    id_alu_conf,
  input  logic          id_sign,
  input  logic          id_src1_shamt,
  input  logic          id_src2_imm,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          id_reg_write,
  input  logic          exm_reg_write,
  input  logic          exm_mem_read,
  input  logic [4:0]    exm_rd,
  input  logic [DW-1:0] exm_result,
  input  logic          mwb_reg_write,
  input  logic [4:0]    mwb_rd,
  input  logic [DW-1:0] mwb_data,
  output logic          stall,
  output logic          ex_valid,
  output logic [4:0]    ex_alu_conf,
  output logic          ex_sign,
  output logic [DW-1:0] ex_in1,
  output logic [DW-1:0] ex_in2,
  output logic [DW-1:0] ex_store_data,
  output logic [4:0]    ex_rd,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_reg_write,
  output logic [SCW-1:0] stall_cnt
);

  typedef struct packed {
    logic          valid;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic [4:0]    shamt;
    logic [4:0]    alu_conf;
    logic          sign;
    logic          src1_shamt;
    logic          src2_imm;
    logic          mem_read;
    logic          mem_write;
    logic          reg_write;
  } stage_t;

  stage_t         stage_q;
  stage_t         stage_d;
  stage_t         id_fields;
  logic [SCW-1:0] stall_cnt_q;
  logic [SCW-1:0] stall_cnt_d;
  logic           load_use;
  logic           bubble;
  logic [DW-1:0]  fwd_rs;
  logic [DW-1:0]  fwd_rt;

  always_comb begin
    id_fields            = '0;
    id_fields.valid      = id_valid;
    id_fields.rs         = id_rs;
    id_fields.rt         = id_rt;
    id_fields.rd         = id_rd;
    id_fields.rs_data    = id_rs_data;
    id_fields.rt_data    = id_rt_data;
    id_fields.imm        = id_imm;
    id_fields.shamt      = id_shamt;
    id_fields.alu_conf   = id_alu_conf;
    id_fields.sign       = id_sign;
    id_fields.src1_shamt = id_src1_shamt;
    id_fields.src2_imm   = id_src2_imm;
    id_fields.mem_read   = id_mem_read;
    id_fields.mem_write  = id_mem_write;
    id_fields.reg_write  = id_reg_write;
  end

  // A load in EX cannot forward in time, so a dependent ID instruction waits.
  always_comb begin
    load_use = stage_q.valid & stage_q.mem_read & (stage_q.rd != 5'd0) & id_valid &
               ((id_uses_rs & (id_rs == stage_q.rd)) |
                (id_uses_rt & (id_rt == stage_q.rd)));
  end

  assign stall  = load_use & ~flush & ~hold;
  assign bubble = flush | load_use | ~id_valid;

  always_comb begin
    stage_d = stage_q;
    if (!hold) begin
      if (bubble) begin
        stage_d = '0;
      end else begin
        stage_d = id_fields;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {SCW{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      stage_q     <= stage_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // EX/MEM loads are excluded: their data only exists once they reach MEM/WB.
  always_comb begin
    fwd_rs = stage_q.rs_data;
    if (exm_reg_write && !exm_mem_read && (exm_rd != 5'd0) && (exm_rd == stage_q.rs)) begin
      fwd_rs = exm_result;
    end else if (mwb_reg_write && (mwb_rd != 5'd0) && (mwb_rd == stage_q.rs)) begin
      fwd_rs = mwb_data;
    end
  end

  always_comb begin
    fwd_rt = stage_q.rt_data;
    if (exm_reg_write && !exm_mem_read && (exm_rd != 5'd0) && (exm_rd == stage_q.rt)) begin
      fwd_rt = exm_result;
    end else if (mwb_reg_write && (mwb_rd != 5'd0) && (mwb_rd == stage_q.rt)) begin
      fwd_rt = mwb_data;
    end
  end

  always_comb begin
    ex_in1        = stage_q.src1_shamt ? {{(DW-5){1'b0}}, stage_q.shamt} : fwd_rs;
    ex_in2        = stage_q.src2_imm ? stage_q.imm : fwd_rt;
    ex_store_data = fwd_rt;
  end

  assign ex_valid     = stage_q.valid;
  assign ex_alu_conf  = stage_q.alu_conf;
  assign ex_sign      = stage_q.sign;
  assign ex_rd        = stage_q.rd;
  assign ex_mem_read  = stage_q.mem_read;
  assign ex_mem_write = stage_q.mem_write;
  assign ex_reg_write = stage_q.reg_write;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed self-checking bench for id_ex_operand_stage; a second instance with a
// narrow stall counter exercises saturation in a short run.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hold, flush, id_valid;
  logic [4:0]  id_rs, id_rt, id_rd, id_shamt, id_alu_conf;
  logic        id_uses_rs, id_uses_rt, id_sign, id_src1_shamt, id_src2_imm;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic        id_mem_read, id_mem_write, id_reg_write;
  logic        exm_reg_write, exm_mem_read, mwb_reg_write;
  logic [4:0]  exm_rd, mwb_rd;
  logic [31:0] exm_result, mwb_data;

  logic        stall, ex_valid, ex_sign, ex_mem_read, ex_mem_write, ex_reg_write;
  logic [4:0]  ex_alu_conf, ex_rd;
  logic [31:0] ex_in1, ex_in2, ex_store_data;
  logic [15:0] stall_cnt;

  logic        s_stall, s_ex_valid, s_ex_sign, s_ex_mem_read, s_ex_mem_write, s_ex_reg_write;
  logic [4:0]  s_ex_alu_conf, s_ex_rd;
  logic [31:0] s_ex_in1, s_ex_in2, s_ex_store_data;
  logic [3:0]  s_stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage #(.DW(32), .SCW(16)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_shamt(id_shamt), .id_alu_conf(id_alu_conf), .id_sign(id_sign),
    .id_src1_shamt(id_src1_shamt), .id_src2_imm(id_src2_imm),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
    .exm_reg_write(exm_reg_write), .exm_mem_read(exm_mem_read), .exm_rd(exm_rd),
    .exm_result(exm_result), .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd),
    .mwb_data(mwb_data), .stall(stall), .ex_valid(ex_valid), .ex_alu_conf(ex_alu_conf),
    .ex_sign(ex_sign), .ex_in1(ex_in1), .ex_in2(ex_in2), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .stall_cnt(stall_cnt)
  );

  id_ex_operand_stage #(.DW(32), .SCW(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_shamt(id_shamt), .id_alu_conf(id_alu_conf), .id_sign(id_sign),
    .id_src1_shamt(id_src1_shamt), .id_src2_imm(id_src2_imm),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
    .exm_reg_write(exm_reg_write), .exm_mem_read(exm_mem_read), .exm_rd(exm_rd),
    .exm_result(exm_result), .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd),
    .mwb_data(mwb_data), .stall(s_stall), .ex_valid(s_ex_valid), .ex_alu_conf(s_ex_alu_conf),
    .ex_sign(s_ex_sign), .ex_in1(s_ex_in1), .ex_in2(s_ex_in2), .ex_store_data(s_ex_store_data),
    .ex_rd(s_ex_rd), .ex_mem_read(s_ex_mem_read), .ex_mem_write(s_ex_mem_write),
    .ex_reg_write(s_ex_reg_write), .stall_cnt(s_stall_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  task automatic clearInputs();
    hold = 0; flush = 0; id_valid = 0;
    id_rs = 0; id_rt = 0; id_rd = 0; id_uses_rs = 0; id_uses_rt = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_shamt = 0; id_alu_conf = 0;
    id_sign = 0; id_src1_shamt = 0; id_src2_imm = 0;
    id_mem_read = 0; id_mem_write = 0; id_reg_write = 0;
    exm_reg_write = 0; exm_mem_read = 0; exm_rd = 0; exm_result = 0;
    mwb_reg_write = 0; mwb_rd = 0; mwb_data = 0;
  endtask

  // Valid instruction in ID: rs, rt, rd, uses_rs, uses_rt, rs/rt data, alu op, mem_read, reg_write.
  task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                               input logic urs, input logic urt,
                               input logic [31:0] rsd, input logic [31:0] rtd,
                               input logic [4:0] alu, input logic mr, input logic rw);
    id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd;
    id_uses_rs = urs; id_uses_rt = urt; id_rs_data = rsd; id_rt_data = rtd;
    id_alu_conf = alu; id_mem_read = mr; id_reg_write = rw;
    id_src1_shamt = 0; id_src2_imm = 0; id_imm = 0; id_shamt = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clearInputs();
    rst_n = 0;
    #12;
    checkOutput("reset_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("reset_ctrl", {29'd0, ex_mem_read, ex_mem_write, ex_reg_write}, 32'd0);
    checkOutput("reset_in1", ex_in1, 32'd0);
    checkOutput("reset_in2", ex_in2, 32'd0);
    checkOutput("reset_store", ex_store_data, 32'd0);
    checkOutput("reset_cnt", {16'd0, stall_cnt}, 32'd0);
    rst_n = 1;
    tick();

    // Plain add, no forwarding
    applyStimulus(5'd1, 5'd2, 5'd3, 1, 1, 32'd5, 32'd7, 5'd0, 0, 1);
    #1 checkOutput("add_nostall", {31'd0, stall}, 32'd0);
    tick();
    checkOutput("add_in1", ex_in1, 32'd5);
    checkOutput("add_in2", ex_in2, 32'd7);
    checkOutput("add_conf", {27'd0, ex_alu_conf}, 32'd0);
    checkOutput("add_valid", {31'd0, ex_valid}, 32'd1);
    checkOutput("add_rd", {27'd0, ex_rd}, 32'd3);

    // Dependent on r3: EX/MEM beats MEM/WB
    applyStimulus(5'd3, 5'd2, 5'd5, 1, 1, 32'h99, 32'd7, 5'd2, 0, 1);
    tick();
    exm_reg_write = 1; exm_rd = 3; exm_result = 32'h10;
    mwb_reg_write = 1; mwb_rd = 3; mwb_data = 32'h20;
    #1;
    checkOutput("fwd_exm_wins", ex_in1, 32'h10);
    checkOutput("fwd_rt_none", ex_in2, 32'd7);
    checkOutput("fwd_conf", {27'd0, ex_alu_conf}, 32'd2);
    exm_reg_write = 0;
    #1 checkOutput("fwd_mwb", ex_in1, 32'h20);
    exm_reg_write = 1; exm_mem_read = 1;
    #1 checkOutput("fwd_exm_load_skipped", ex_in1, 32'h20);
    exm_reg_write = 0; exm_mem_read = 0; mwb_reg_write = 0;
    #1 checkOutput("fwd_regfile", ex_in1, 32'h99);

    // Load-use: lw r4 in EX, dependent reads rt=4
    applyStimulus(5'd1, 5'd0, 5'd4, 1, 0, 32'd0, 32'd0, 5'd0, 1, 1);
    id_src2_imm = 1; id_imm = 32'd8;
    tick();
    checkOutput("lw_in2_imm", ex_in2, 32'd8);
    applyStimulus(5'd2, 5'd4, 5'd6, 1, 1, 32'd3, 32'h55, 5'd0, 0, 1);
    #1 checkOutput("lu_stall", {31'd0, stall}, 32'd1);
    tick();
    checkOutput("lu_bubble", {31'd0, ex_valid}, 32'd0);
    checkOutput("lu_bubble_rw", {31'd0, ex_reg_write}, 32'd0);
    checkOutput("lu_cnt", {16'd0, stall_cnt}, 32'd1);
    checkOutput("lu_stall_drop", {31'd0, stall}, 32'd0);
    mwb_reg_write = 1; mwb_rd = 4; mwb_data = 32'hAB;
    tick();
    checkOutput("lu_issue_valid", {31'd0, ex_valid}, 32'd1);
    checkOutput("lu_fwd_in2", ex_in2, 32'hAB);
    checkOutput("lu_store", ex_store_data, 32'hAB);
    checkOutput("lu_in1", ex_in1, 32'd3);
    checkOutput("lu_cnt_hold", {16'd0, stall_cnt}, 32'd1);
    mwb_reg_write = 0;

    // Register 0 never forwarded; shamt select
    applyStimulus(5'd0, 5'd2, 5'd7, 1, 1, 32'd0, 32'd9, 5'd0, 0, 1);
    tick();
    exm_reg_write = 1; exm_rd = 0; exm_result = 32'hFF;
    mwb_reg_write = 1; mwb_rd = 0; mwb_data = 32'hEE;
    #1 checkOutput("r0_no_fwd", ex_in1, 32'd0);
    applyStimulus(5'd0, 5'd2, 5'd7, 0, 1, 32'd0, 32'd9, 5'd0, 0, 1);
    id_src1_shamt = 1; id_shamt = 5'd31;
    tick();
    checkOutput("shamt_in1", ex_in1, 32'd31);
    exm_reg_write = 0; mwb_reg_write = 0;

    // Flush together with load-use
    applyStimulus(5'd1, 5'd0, 5'd4, 1, 0, 32'd0, 32'd0, 5'd0, 1, 1);
    tick();
    applyStimulus(5'd4, 5'd2, 5'd6, 1, 1, 32'd1, 32'd2, 5'd0, 0, 1);
    flush = 1;
    #1 checkOutput("flush_lu_stall", {31'd0, stall}, 32'd0);
    tick();
    checkOutput("flush_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("flush_rw", {31'd0, ex_reg_write}, 32'd0);
    checkOutput("flush_cnt", {16'd0, stall_cnt}, 32'd1);
    flush = 0;

    // Hold freezes the stage even against flush and new ID contents
    applyStimulus(5'd1, 5'd2, 5'd8, 1, 1, 32'h11, 32'h22, 5'd3, 0, 1);
    tick();
    checkOutput("pre_hold_in1", ex_in1, 32'h11);
    hold = 1; flush = 1;
    applyStimulus(5'd9, 5'd10, 5'd9, 1, 1, 32'h77, 32'h88, 5'd6, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("hold_valid", {31'd0, ex_valid}, 32'd1);
      checkOutput("hold_in1", ex_in1, 32'h11);
      checkOutput("hold_in2", ex_in2, 32'h22);
      checkOutput("hold_rd", {27'd0, ex_rd}, 32'd8);
      checkOutput("hold_conf", {27'd0, ex_alu_conf}, 32'd3);
    end
    hold = 0; flush = 0;

    // Repeated self-dependent loads: one stall every two cycles
    applyStimulus(5'd4, 5'd0, 5'd4, 1, 0, 32'd0, 32'd0, 5'd0, 1, 1);
    for (int i = 0; i < 21; i++) begin
      tick();
      tick();
    end
    checkOutput("cnt_exact", {16'd0, stall_cnt}, 32'd22);
    checkOutput("cnt_saturated", {28'd0, s_stall_cnt}, 32'hF);

    // Async reset while a stall is pending
    tick();
    checkOutput("pre_reset_stall", {31'd0, stall}, 32'd1);
    #2 rst_n = 0;
    #1;
    checkOutput("areset_stall", {31'd0, stall}, 32'd0);
    checkOutput("areset_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("areset_mr", {31'd0, ex_mem_read}, 32'd0);
    checkOutput("areset_cnt", {16'd0, stall_cnt}, 32'd0);
    checkOutput("areset_in1", ex_in1, 32'd0);
    #3 rst_n = 1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register and operand-select stage sitting directly upstream of the EX-stage ALU.
- Latches decoded fields from ID and resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards and inserts a one-cycle bubble.
- Drives the ALU's ALUConf, Sign, In1 and In2, plus the control and data the MEM stage needs.

Parameters:
DW, 32, datapath width
SCW, 16, width of the saturating stall counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
hold  in  1  global freeze; stage register keeps its value
flush  in  1  kill the instruction in ID (branch/jump taken)
id_valid  in  1  ID holds a real instruction
id_rs, id_rt, id_rd  in  5 each  source and destination register numbers
id_uses_rs, id_uses_rt  in  1 each  instruction reads rs / rt
id_rs_data, id_rt_data  in  DW each  register-file read data
id_imm  in  DW  extended immediate
id_shamt  in  5  shift amount
id_alu_conf  in  5  ALU operation code
id_sign  in  1  signed compare
id_src1_shamt  in  1  In1 = zero-extended shamt
id_src2_imm  in  1  In2 = imm
id_mem_read, id_mem_write, id_reg_write  in  1 each  downstream control
exm_reg_write, exm_mem_read  in  1 each  EX/MEM control
exm_rd  in  5  EX/MEM destination
exm_result  in  DW  EX/MEM ALU result
mwb_reg_write  in  1  MEM/WB write enable
mwb_rd  in  5  MEM/WB destination
mwb_data  in  DW  MEM/WB writeback data
stall  out  1  hold PC and IF/ID this cycle
ex_valid  out  1  EX holds a real instruction
ex_alu_conf  out  5  ALU operation code
ex_sign  out  1  signed compare
ex_in1, ex_in2  out  DW each  ALU operands
ex_store_data  out  DW  forwarded rt value for stores
ex_rd  out  5  destination register
ex_mem_read, ex_mem_write, ex_reg_write  out  1 each  downstream control
stall_cnt  out  SCW  saturating count of load-use stall cycles

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All registered fields clear to 0, so ex_valid=0 and all controls are 0.
  - stall_cnt=0.
  - ex_in1, ex_in2 and ex_store_data read 0 provided the forward sources are idle.
- Load-use hazard (combinational), lu = all of:
  - ex_valid & ex_mem_read & ex_rd!=0 & id_valid
  - (id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)
- stall = lu & ~flush & ~hold.
- Register update each rising edge, priority hold > flush > lu > load:
  - hold: all fields unchanged; stall_cnt unchanged.
  - flush or lu: load a bubble. Bubble = valid, reg_write, mem_read, mem_write and rd all 0; other fields 0.
  - otherwise: load all id_* fields. id_valid=0 also produces a bubble.
- stall_cnt increments by 1 on each edge where stall=1 and saturates at all-ones.
- Forwarding (combinational, from registered rs/rt, done separately for rs and rt):
  - Priority 1: exm_reg_write & ~exm_mem_read & exm_rd!=0 & exm_rd==reg gives exm_result.
  - Priority 2: mwb_reg_write & mwb_rd!=0 & mwb_rd==reg gives mwb_data.
  - Otherwise: the registered read data.
  - Register 0 is never forwarded. An EX/MEM load is never forwarded; the load-use stall guarantees it is in MEM/WB by then.
- Operand select:
  - ex_in1 = src1_shamt ? {zeros, shamt} : fwd_rs.
  - ex_in2 = src2_imm ? imm : fwd_rt.
  - ex_store_data = fwd_rt always.
- Latency: one cycle from ID to EX outputs. Operand outputs are combinational from registered state and the forward inputs.
- Simultaneous flush and lu: the bubble is inserted and stall=0, so the flushed instruction is discarded rather than retained.
- Reset asserted mid-stall: stall drops once ex_valid clears.

Test Plan:
- Reset, then id add rs=1 rt=2 rd=3 with data 5/7, no forwards -> next cycle ex_in1=5, ex_in2=7, ex_alu_conf=0, ex_valid=1, stall=0.
- EX holds add rd=3; next instr uses rs=3; exm_reg_write=1, exm_rd=3, exm_result=0x10, mwb_rd=3, mwb_data=0x20 -> ex_in1=0x10 (EX/MEM wins).
- lw rd=4 in EX, then ID instr uses rt=4 -> stall=1 for one cycle, bubble (ex_valid=0) next, stall_cnt=1. Dependent issues next with mwb_rd=4, mwb_data=0xAB -> ex_in2=0xAB.
- Forward to register 0: exm_rd=0, exm_reg_write=1, exm_result=0xFF, rs=0, rs_data=0 -> ex_in1=0. src1_shamt=1, shamt=31 -> ex_in1=31.
- flush=1 together with a load-use condition -> stall=0, next ex_valid=0, ex_reg_write=0. With hold=1 the outputs keep their prior values across 3 cycles.
- Force 2^SCW+5 stall cycles -> stall_cnt saturates at 0xFFFF. Async rst_n pulse mid-cycle -> outputs zero immediately.
